// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared light encodings and phase type for the traffic lights.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/rr_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : rr_next_sel
// Description : Combinational round-robin search for the next requesting
//               approach, starting after cur_idx and excluding it.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_next_sel #(
    parameter int NUM_DIR = 2
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [2:0]         cur_idx,
    output logic [2:0]         next_idx,
    output logic               any_req
);

    logic [7:0] w_req_ext;
    logic [2:0] w_cand;

    assign w_req_ext = 8'(req);

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        next_idx = 3'd0;
        any_req  = 1'b0;
        w_cand   = 3'd0;
        for (int k = NUM_DIR - 1; k >= 1; k--) begin
            w_cand = 3'((int'(cur_idx) + k) % NUM_DIR);
            if (w_req_ext[w_cand]) begin
                next_idx = w_cand;
                any_req  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_multi_cntr.sv
`default_nettype none
// ============================================================================
// Module      : tl_multi_cntr
// Description : Round-robin N-approach traffic light controller with timed
//               GREEN / YELLOW / ALL-RED phases and a countdown output.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_multi_cntr
    import tl_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 10,
    parameter int MAX_GREEN  = 30,
    parameter int YELLOW_CYC = 5,
    parameter int ALLRED_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [NUM_DIR-1:0]   Tsense,
    output logic [2*NUM_DIR-1:0] Light,
    output logic [2:0]           Active_idx,
    output logic [1:0]           Phase,
    output logic [CNT_W-1:0]     Remain
);

    localparam longint C_CNT_LIMIT = (longint'(1) << CNT_W) - 1;

    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
        $error("tl_multi_cntr: NUM_DIR must be in 2..8");
    end
    if (longint'(MAX_GREEN) - 1 > C_CNT_LIMIT) begin : g_bad_max_green
        $error("tl_multi_cntr: MAX_GREEN-1 does not fit in CNT_W");
    end
    if (longint'(YELLOW_CYC) - 1 > C_CNT_LIMIT) begin : g_bad_yellow
        $error("tl_multi_cntr: YELLOW_CYC-1 does not fit in CNT_W");
    end
    if (ALLRED_CYC > 0 && longint'(ALLRED_CYC) - 1 > C_CNT_LIMIT) begin : g_bad_allred
        $error("tl_multi_cntr: ALLRED_CYC-1 does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0]     C_MIN_M1    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0]     C_MAX_M1    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0]     C_YEL_M1    = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0]     C_AR_M1     = CNT_W'(ALLRED_CYC - 1);
    localparam bit                   C_SKIP_AR   = (ALLRED_CYC == 0);
    localparam logic [2*NUM_DIR-1:0] C_LIGHT_RST = {{(NUM_DIR-1){L_RED}}, L_GREEN};

    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_active;
    logic [2:0]       r_next;

    phase_t           w_phase_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_active_nxt;
    logic [2:0]       w_next_nxt;

    logic [2*NUM_DIR-1:0] w_light_nxt;
    logic [CNT_W-1:0]     w_remain_nxt;

    logic [7:0] w_ts_ext;
    logic [2:0] w_rr_idx;
    logic       w_other_req;
    logic       w_own_req;
    logic       w_green_exit;

    rr_next_sel #(
        .NUM_DIR (NUM_DIR)
    ) u_rr_next_sel (
        .req      (Tsense),
        .cur_idx  (r_active),
        .next_idx (w_rr_idx),
        .any_req  (w_other_req)
    );

    assign w_ts_ext  = 8'(Tsense);
    assign w_own_req = w_ts_ext[r_active];

    // Early release needs the owner to have gone idle; the max limit does not.
    assign w_green_exit = w_other_req &&
                          (((r_cnt >= C_MIN_M1) && !w_own_req) || (r_cnt >= C_MAX_M1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_phase  <= PH_GREEN;
            r_cnt    <= '0;
            r_active <= 3'd0;
            r_next   <= 3'd0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
            r_next   <= w_next_nxt;
        end
    end

    always_comb begin
        w_phase_nxt  = r_phase;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_next_nxt   = r_next;
        case (r_phase)
            PH_GREEN: begin
                if (w_green_exit) begin
                    w_phase_nxt = PH_YELLOW;
                    w_cnt_nxt   = '0;
                    w_next_nxt  = w_rr_idx;
                end else if (r_cnt != C_MAX_M1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PH_YELLOW: begin
                if (r_cnt == C_YEL_M1) begin
                    w_cnt_nxt = '0;
                    if (C_SKIP_AR) begin
                        w_phase_nxt  = PH_GREEN;
                        w_active_nxt = r_next;
                    end else begin
                        w_phase_nxt = PH_ALLRED;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PH_ALLRED: begin
                if (r_cnt == C_AR_M1) begin
                    w_phase_nxt  = PH_GREEN;
                    w_cnt_nxt    = '0;
                    w_active_nxt = r_next;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_phase_nxt = PH_GREEN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        w_light_nxt = {NUM_DIR{L_RED}};
        for (int i = 0; i < NUM_DIR; i++) begin
            if (3'(i) == w_active_nxt) begin
                if (w_phase_nxt == PH_GREEN) begin
                    w_light_nxt[2*i +: 2] = L_GREEN;
                end else if (w_phase_nxt == PH_YELLOW) begin
                    w_light_nxt[2*i +: 2] = L_YELLOW;
                end
            end
        end
        case (w_phase_nxt)
            PH_GREEN:  w_remain_nxt = (w_cnt_nxt >= C_MAX_M1) ? '0 : (C_MAX_M1 - w_cnt_nxt);
            PH_YELLOW: w_remain_nxt = C_YEL_M1 - w_cnt_nxt;
            PH_ALLRED: w_remain_nxt = C_AR_M1 - w_cnt_nxt;
            default:   w_remain_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            Light      <= C_LIGHT_RST;
            Active_idx <= 3'd0;
            Phase      <= PH_GREEN;
            Remain     <= C_MAX_M1;
        end else begin
            Light      <= w_light_nxt;
            Active_idx <= w_active_nxt;
            Phase      <= w_phase_nxt;
            Remain     <= w_remain_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_multi_cntr.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_multi_cntr
// Description : Directed vector bench for a default 2-way and a 4-way
//               (no all-red) instance of tl_multi_cntr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_multi_cntr;

    typedef struct {
        logic       rst;
        logic [3:0] ts;
        int         n;
        logic [7:0] light;
        logic [1:0] ph;
        logic [2:0] act;
        logic [7:0] rem;
    } vec_t;

    logic       clk;
    logic       rst2;
    logic [1:0] ts2;
    logic [3:0] light2;
    logic [2:0] act2;
    logic [1:0] ph2;
    logic [7:0] rem2;

    logic       rst4;
    logic [3:0] ts4;
    logic [7:0] light4;
    logic [2:0] act4;
    logic [1:0] ph4;
    logic [7:0] rem4;

    int n_tests;
    int n_fail;

    vec_t v2[20];
    vec_t v4[11];

    tl_multi_cntr u_dut2 (
        .CLK        (clk),
        .Reset      (rst2),
        .Tsense     (ts2),
        .Light      (light2),
        .Active_idx (act2),
        .Phase      (ph2),
        .Remain     (rem2)
    );

    tl_multi_cntr #(
        .NUM_DIR    (4),
        .CNT_W      (8),
        .MIN_GREEN  (2),
        .MAX_GREEN  (6),
        .YELLOW_CYC (2),
        .ALLRED_CYC (0)
    ) u_dut4 (
        .CLK        (clk),
        .Reset      (rst4),
        .Tsense     (ts4),
        .Light      (light4),
        .Active_idx (act4),
        .Phase      (ph4),
        .Remain     (rem4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] ts, input int n,
                                input logic [7:0] l, input logic [1:0] p,
                                input logic [2:0] a, input logic [7:0] rm);
        vec_t v;
        v.rst = r; v.ts = ts; v.n = n; v.light = l; v.ph = p; v.act = a; v.rem = rm;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b required %b", name, idx, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input int idx, input logic [3:0] l,
                        input logic [1:0] p, input logic [2:0] a, input logic [7:0] rm);
        cmp({tag, ".light"},  idx, {4'b0, light2}, {4'b0, l});
        cmp({tag, ".phase"},  idx, {6'b0, ph2},    {6'b0, p});
        cmp({tag, ".active"}, idx, {5'b0, act2},   {5'b0, a});
        cmp({tag, ".remain"}, idx, rem2,           rm);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst2 = 1'b1; ts2 = 2'b00;
        rst4 = 1'b1; ts4 = 4'b0000;

        // Two-way, defaults: idle hold, single request, then both requesting.
        v2[0]  = mk(1, 4'b00,  1, 8'b1000, 0, 0, 29);
        v2[1]  = mk(0, 4'b00,  5, 8'b1000, 0, 0, 24);
        v2[2]  = mk(0, 4'b00, 95, 8'b1000, 0, 0, 0);
        v2[3]  = mk(0, 4'b10,  1, 8'b1001, 1, 0, 4);
        v2[4]  = mk(0, 4'b10,  4, 8'b1001, 1, 0, 0);
        v2[5]  = mk(0, 4'b10,  1, 8'b1010, 2, 0, 1);
        v2[6]  = mk(0, 4'b10,  1, 8'b1010, 2, 0, 0);
        v2[7]  = mk(0, 4'b10,  1, 8'b0010, 0, 1, 29);
        v2[8]  = mk(1, 4'b10,  1, 8'b1000, 0, 0, 29);
        v2[9]  = mk(0, 4'b10,  9, 8'b1000, 0, 0, 20);
        v2[10] = mk(0, 4'b10,  1, 8'b1001, 1, 0, 4);
        v2[11] = mk(0, 4'b10,  5, 8'b1010, 2, 0, 1);
        v2[12] = mk(0, 4'b10,  2, 8'b0010, 0, 1, 29);
        v2[13] = mk(0, 4'b11, 29, 8'b0010, 0, 1, 0);
        v2[14] = mk(0, 4'b11,  1, 8'b0110, 1, 1, 4);
        v2[15] = mk(0, 4'b11,  5, 8'b1010, 2, 1, 1);
        v2[16] = mk(0, 4'b11,  2, 8'b1000, 0, 0, 29);
        v2[17] = mk(0, 4'b11, 29, 8'b1000, 0, 0, 0);
        v2[18] = mk(0, 4'b11,  1, 8'b1001, 1, 0, 4);
        v2[19] = mk(0, 4'b11,  7, 8'b0010, 0, 1, 29);

        // Four-way: round-robin skip, latched target, wrap to 0.
        v4[0]  = mk(1, 4'b0000, 1, 8'b10101000, 0, 0, 5);
        v4[1]  = mk(0, 4'b0010, 1, 8'b10101000, 0, 0, 4);
        v4[2]  = mk(0, 4'b0010, 1, 8'b10101001, 1, 0, 1);
        v4[3]  = mk(0, 4'b0010, 1, 8'b10101001, 1, 0, 0);
        v4[4]  = mk(0, 4'b0010, 1, 8'b10100010, 0, 1, 5);
        v4[5]  = mk(0, 4'b1001, 2, 8'b10100110, 1, 1, 1);
        v4[6]  = mk(0, 4'b0100, 1, 8'b10100110, 1, 1, 0);
        v4[7]  = mk(0, 4'b0100, 1, 8'b00101010, 0, 3, 5);
        v4[8]  = mk(0, 4'b1001, 5, 8'b00101010, 0, 3, 0);
        v4[9]  = mk(0, 4'b1001, 1, 8'b01101010, 1, 3, 1);
        v4[10] = mk(0, 4'b1001, 2, 8'b10101000, 0, 0, 5);

        for (int i = 0; i < 20; i++) begin
            rst2 = v2[i].rst;
            ts2  = v2[i].ts[1:0];
            repeat (v2[i].n) tick();
            chk2("d2", i, v2[i].light[3:0], v2[i].ph, v2[i].act, v2[i].rem);
        end

        // Reset on the third yellow cycle returns straight to the reset state.
        ts2 = 2'b01;
        repeat (10) tick();
        chk2("y_entry", 0, 4'b0110, 2'd1, 3'd1, 8'd4);
        repeat (2) tick();
        chk2("y_third", 0, 4'b0110, 2'd1, 3'd1, 8'd2);
        rst2 = 1'b1;
        tick();
        chk2("mid_rst", 0, 4'b1000, 2'd0, 3'd0, 8'd29);
        rst2 = 1'b0;
        ts2  = 2'b00;

        // Idle countdown saturates at zero.
        for (int k = 1; k <= 35; k++) begin
            tick();
            cmp("idle_remain", k, rem2, (k >= 29) ? 8'd0 : 8'(29 - k));
        end
        cmp("idle_light", 0, {4'b0, light2}, 8'b0000_1000);

        for (int i = 0; i < 11; i++) begin
            rst4 = v4[i].rst;
            ts4  = v4[i].ts;
            repeat (v4[i].n) tick();
            cmp("d4.light",  i, light4,        v4[i].light);
            cmp("d4.phase",  i, {6'b0, ph4},   {6'b0, v4[i].ph});
            cmp("d4.active", i, {5'b0, act4},  {5'b0, v4[i].act});
            cmp("d4.remain", i, rem4,          v4[i].rem);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
